// File: rtl/reg_bank_pkg.sv
// Shared datapath constants for the register file and the destination select.
// The fixed register numbers here are the ones the destination select must also use.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_num_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_num_t  REG_ZERO         = reg_num_t'(0);
    localparam reg_num_t  REG_SP           = reg_num_t'(29);
    localparam reg_num_t  REG_RA           = reg_num_t'(31);
    localparam reg_data_t SP_RESET_DEFAULT = 32'd227;

    // Write-port bundle handed to each read port for bypass decisions.
    typedef struct packed {
        logic      we;
        reg_num_t  addr;
        reg_data_t data;
    } wr_port_t;

    function automatic logic is_zero_reg(input reg_num_t num);
        return num == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register file bus: two registered read ports, one write port, sticky $0-write flag.
// The master drives addresses, load enables and the write port; the slave returns operands.
interface reg_bank_if;
    import reg_bank_pkg::*;

    reg_num_t  rs_addr;
    reg_num_t  rt_addr;
    logic      a_load;
    logic      b_load;
    logic      reg_write;
    reg_num_t  wr_addr;
    reg_data_t wr_data;
    reg_data_t a_out;
    reg_data_t b_out;
    logic      zero_write;

    modport master (
        output rs_addr, rt_addr, a_load, b_load, reg_write, wr_addr, wr_data,
        input  a_out, b_out, zero_write
    );

    modport slave (
        input  rs_addr, rt_addr, a_load, b_load, reg_write, wr_addr, wr_data,
        output a_out, b_out, zero_write
    );

endinterface

// File: rtl/reg_bank_read_port.sv
// Combinational read-port selector: forces $0 to zero and forwards a same-cycle
// write to the same register (write-first) ahead of the stored array value.
module reg_bank_read_port
    import reg_bank_pkg::*;
(
    input  reg_num_t  i_addr,
    input  wr_port_t  i_wr,
    input  reg_data_t i_arr_val,
    output reg_data_t o_value
);

    always_comb begin
        o_value = i_arr_val;
        if (is_zero_reg(i_addr)) begin
            o_value = '0;
        end else if (i_wr.we && (i_wr.addr == i_addr)) begin
            o_value = i_wr.data;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32 register file with registered A/B operand outputs, write-first bypass,
// hard-wired $0 and a sticky flag recording any attempted write to $0.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter reg_data_t SP_RESET = SP_RESET_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_bank_if.slave  bus
);

    // Every register needs a reset value ($29 is non-zero), so the array is flops.
    logic [NUM_REGS-1:0][DATA_W-1:0] w_regs;
    wr_port_t  w_wr;
    reg_data_t w_a_value;
    reg_data_t w_b_value;
    reg_data_t r_a_out;
    reg_data_t r_b_out;
    logic      r_zero_write;

    assign w_wr.we   = bus.reg_write;
    assign w_wr.addr = bus.wr_addr;
    assign w_wr.data = bus.wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == int'(REG_ZERO)) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_gpr
                localparam reg_num_t NUM = reg_num_t'(gi);
                localparam reg_data_t RST_VAL = (NUM == REG_SP) ? SP_RESET : '0;
                reg_data_t r_q;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_q <= RST_VAL;
                    end else if (w_wr.we && (w_wr.addr == NUM)) begin
                        r_q <= w_wr.data;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    reg_bank_read_port u_port_a (
        .i_addr    (bus.rs_addr),
        .i_wr      (w_wr),
        .i_arr_val (w_regs[bus.rs_addr]),
        .o_value   (w_a_value)
    );

    reg_bank_read_port u_port_b (
        .i_addr    (bus.rt_addr),
        .i_wr      (w_wr),
        .i_arr_val (w_regs[bus.rt_addr]),
        .o_value   (w_b_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_out      <= '0;
            r_b_out      <= '0;
            r_zero_write <= 1'b0;
        end else begin
            if (bus.a_load) begin
                r_a_out <= w_a_value;
            end
            if (bus.b_load) begin
                r_b_out <= w_b_value;
            end
            if (w_wr.we && is_zero_reg(w_wr.addr)) begin
                r_zero_write <= 1'b1;
            end
        end
    end

    assign bus.a_out      = r_a_out;
    assign bus.b_out      = r_b_out;
    assign bus.zero_write = r_zero_write;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a behavioural register-file model checked every
// cycle, plus hand-computed literal expectations at key points of the sequence.
module tb_reg_bank;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    reg_bank_if bus ();

    reg_bank dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain array of register contents plus operand latches.
    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b;
    logic        m_zw;

    function automatic logic [31:0] m_value(input logic [4:0] x);
        if (x == 5'd0) return 32'h0;
        if (bus.reg_write && bus.wr_addr == x) return bus.wr_data;
        return m_regs[x];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= (i == 29) ? 32'd227 : 32'd0;
            m_a  <= 32'd0;
            m_b  <= 32'd0;
            m_zw <= 1'b0;
        end else begin
            if (bus.a_load) m_a <= m_value(bus.rs_addr);
            if (bus.b_load) m_b <= m_value(bus.rt_addr);
            if (bus.reg_write) begin
                if (bus.wr_addr == 5'd0) m_zw <= 1'b1;
                else m_regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_a_out", bus.a_out, m_a);
        chk("model_b_out", bus.b_out, m_b);
        chk("model_zero_write", {31'd0, bus.zero_write}, {31'd0, m_zw});
    end

    task automatic idle();
        bus.a_load    = 1'b0;
        bus.b_load    = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.reg_write = 1'b1;
        bus.wr_addr   = a;
        bus.wr_data   = d;
    endtask

    task automatic ld(input logic la, input logic [4:0] ra, input logic lb, input logic [4:0] rb);
        bus.a_load  = la;
        bus.rs_addr = ra;
        bus.b_load  = lb;
        bus.rt_addr = rb;
    endtask

    initial begin
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        idle();
        #2;
        chk("reset_a", bus.a_out, 32'h0);
        chk("reset_b", bus.b_out, 32'h0);
        chk("reset_zw", {31'd0, bus.zero_write}, 32'h0);
        #10 reset_n = 1'b1;

        // Reset values
        ld(1, 5'd29, 1, 5'd5);
        step();
        $display("txn reset_read a=0x%08h b=0x%08h zw=%0d", bus.a_out, bus.b_out, bus.zero_write);
        chk("sp_reset", bus.a_out, 32'd227);
        chk("r5_reset", bus.b_out, 32'h0);
        chk("zw_after_reset", {31'd0, bus.zero_write}, 32'h0);
        idle();

        // Write then read
        wr(5'd8, 32'hDEADBEEF);
        step();
        idle();
        ld(1, 5'd8, 1, 5'd9);
        step();
        $display("txn write_read a=0x%08h b=0x%08h", bus.a_out, bus.b_out);
        chk("r8_read", bus.a_out, 32'hDEADBEEF);
        chk("r9_untouched", bus.b_out, 32'h0);
        idle();

        // Bypass on both ports from the same write
        wr(5'd31, 32'h00400010);
        ld(1, 5'd31, 1, 5'd31);
        step();
        $display("txn bypass a=0x%08h b=0x%08h", bus.a_out, bus.b_out);
        chk("bypass_a", bus.a_out, 32'h00400010);
        chk("bypass_b", bus.b_out, 32'h00400010);
        idle();

        // $0 protection
        wr(5'd0, 32'hFFFFFFFF);
        ld(1, 5'd0, 0, 5'd0);
        step();
        $display("txn zero_write a=0x%08h zw=%0d", bus.a_out, bus.zero_write);
        chk("zw_set", {31'd0, bus.zero_write}, 32'h1);
        chk("r0_same_edge", bus.a_out, 32'h0);
        idle();
        ld(1, 5'd0, 0, 5'd0);
        step();
        chk("r0_later", bus.a_out, 32'h0);
        idle();
        repeat (10) step();
        $display("txn zero_sticky zw=%0d", bus.zero_write);
        chk("zw_sticky", {31'd0, bus.zero_write}, 32'h1);

        // Load hold
        wr(5'd10, 32'h12345678);
        step();
        idle();
        ld(1, 5'd10, 0, 5'd0);
        step();
        chk("hold_capture", bus.a_out, 32'h12345678);
        idle();
        wr(5'd10, 32'hCAFEF00D);
        bus.rs_addr = 5'd8;
        step();
        chk("hold_1", bus.a_out, 32'h12345678);
        idle();
        bus.rs_addr = 5'd31;
        step();
        chk("hold_2", bus.a_out, 32'h12345678);
        bus.rs_addr = 5'd10;
        step();
        $display("txn load_hold a=0x%08h", bus.a_out);
        chk("hold_3", bus.a_out, 32'h12345678);
        ld(1, 5'd10, 0, 5'd0);
        step();
        chk("r10_new", bus.a_out, 32'hCAFEF00D);
        idle();

        // Async reset mid-stream
        wr(5'd29, 32'h00000100);
        step();
        idle();
        ld(1, 5'd29, 1, 5'd8);
        step();
        chk("sp_written", bus.a_out, 32'h00000100);
        chk("r8_before_reset", bus.b_out, 32'hDEADBEEF);
        idle();
        #2 reset_n = 1'b0;
        #1;
        $display("txn async_reset a=0x%08h b=0x%08h zw=%0d", bus.a_out, bus.b_out, bus.zero_write);
        chk("async_a", bus.a_out, 32'h0);
        chk("async_b", bus.b_out, 32'h0);
        chk("async_zw", {31'd0, bus.zero_write}, 32'h0);
        wr(5'd29, 32'h00000055);
        step();
        idle();
        #2 reset_n = 1'b1;
        ld(1, 5'd29, 1, 5'd8);
        step();
        $display("txn after_reset a=0x%08h b=0x%08h", bus.a_out, bus.b_out);
        chk("sp_after_reset", bus.a_out, 32'd227);
        chk("r8_after_reset", bus.b_out, 32'h0);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
